// File: rtl/qos_pkg.sv
// QoS output scheduler shared definitions: queue ids, depth, weight tables,
// FSM state encoding and occupancy/weight helpers.
package qos_pkg;

    localparam int QDEPTH = 6;
    localparam int WGT_W  = 6;

    typedef logic [WGT_W-1:0] wgt_t;

    localparam logic [1:0] QID_Q1 = 2'b00;
    localparam logic [1:0] QID_Q2 = 2'b01;
    localparam logic [1:0] QID_Q3 = 2'b10;
    localparam logic [1:0] QID_Q4 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    // Tables indexed by saturated occupancy 0..6 (element [0] is occ 0).
    localparam logic [6:0][WGT_W-1:0] W_Q1 =
        {6'd19, 6'd17, 6'd16, 6'd15, 6'd13, 6'd9, 6'd0};
    localparam logic [6:0][WGT_W-1:0] W_Q2 =
        {6'd21, 6'd18, 6'd14, 6'd12, 6'd8, 6'd6, 6'd0};
    localparam logic [6:0][WGT_W-1:0] W_Q3 =
        {6'd23, 6'd19, 6'd11, 6'd7, 6'd5, 6'd3, 6'd0};
    localparam logic [6:0][WGT_W-1:0] W_Q4 =
        {6'd24, 6'd22, 6'd10, 6'd4, 6'd2, 6'd1, 6'd0};

    localparam wgt_t W_OVR = 6'd20;

    function automatic logic [2:0] sat_occ(input logic [2:0] o);
        return (o > 3'(QDEPTH)) ? 3'(QDEPTH) : o;
    endfunction

    function automatic wgt_t weight_of(input logic [1:0] q,
                                       input logic [2:0] o);
        wgt_t w;
        case (q)
            QID_Q1:  w = W_Q1[o];
            QID_Q2:  w = W_Q2[o];
            QID_Q3:  w = W_Q3[o];
            default: w = W_Q4[o];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/qos_weight_arbiter.sv
// Combinational LLQ/WFQ arbiter: occupancies -> weights -> one-hot winner.
// Ports: occ1..occ4 (3b each) in; grant (4b one-hot) out; any_valid out.
module qos_weight_arbiter
    import qos_pkg::*;
(
    input  logic [2:0] occ1,
    input  logic [2:0] occ2,
    input  logic [2:0] occ3,
    input  logic [2:0] occ4,
    output logic [3:0] grant,
    output logic       any_valid
);

    logic [2:0] occ_s [4];
    wgt_t       w     [4];
    wgt_t       best;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        occ_s[0] = sat_occ(occ1);
        occ_s[1] = sat_occ(occ2);
        occ_s[2] = sat_occ(occ3);
        occ_s[3] = sat_occ(occ4);
        for (int i = 0; i < 4; i++) begin
            w[i] = weight_of(2'(i), occ_s[i]);
        end
        // Queue1 full with queue3 nearly full boosts q1, unless q2 is also
        // heavily loaded, in which case q3 gets the boost instead.
        if (occ_s[2] == 3'd5 && occ_s[0] == 3'd6) begin
            if (occ_s[1] < 3'd5) w[0] = W_OVR;
            else                 w[2] = W_OVR;
        end
        best  = '0;
        idx   = '0;
        found = 1'b0;
        // Strict compare keeps the lowest index on ties.
        for (int i = 0; i < 4; i++) begin
            if (occ_s[i] != 3'd0 && (!found || w[i] > best)) begin
                found = 1'b1;
                best  = w[i];
                idx   = 2'(i);
            end
        end
        any_valid = found;
        grant     = found ? (4'b0001 << idx) : 4'b0000;
    end

endmodule

// File: rtl/qos_output_scheduler.sv
// Dequeue end of the 4-queue QoS path: per read tick picks a queue, pops it
// and emits {queue_id, payload}. Ports: clk, reset (async, low), read_tick,
// occ1..4, head1..4 in; pop, out_data, out_valid, ct_received, busy out.
// Optional starvation guard enabled by defining QOS_STARVE_GUARD_EN.
module qos_output_scheduler
    import qos_pkg::*;
#(
    parameter int CNT_W = 10
`ifdef QOS_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read_tick,
    input  logic [2:0]       occ1,
    input  logic [2:0]       occ2,
    input  logic [2:0]       occ3,
    input  logic [2:0]       occ4,
    input  logic [1:0]       head1,
    input  logic [1:0]       head2,
    input  logic [1:0]       head3,
    input  logic [1:0]       head4,
    output logic [3:0]       pop,
    output logic [3:0]       out_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] ct_received,
    output logic             busy
);

    state_e           state_q;
    logic             pending_q;
    logic [3:0]       pop_q;
    logic [3:0]       out_data_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] ct_q;
    logic [CNT_W-1:0] ct_d;

    logic [3:0] arb_grant;
    logic       arb_any;
    logic [3:0] sel_grant;
    logic [1:0] sel_id;
    logic [1:0] sel_head;
    logic [3:0] occ_nz;

    assign occ_nz = {occ4 != 3'd0, occ3 != 3'd0,
                     occ2 != 3'd0, occ1 != 3'd0};

    qos_weight_arbiter u_arb (
        .occ1      (occ1),
        .occ2      (occ2),
        .occ3      (occ3),
        .occ4      (occ4),
        .grant     (arb_grant),
        .any_valid (arb_any)
    );

`ifdef QOS_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q [4];
    logic [SW-1:0] starve_d [4];

    always_comb begin
        sel_grant = arb_grant;
        // Descending scan so the lowest starving index wins.
        for (int i = 3; i >= 0; i--) begin
            if (occ_nz[i] && starve_q[i] >= LIM) begin
                sel_grant = 4'b0001 << i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!occ_nz[i] || sel_grant[i]) starve_d[i] = '0;
            else if (starve_q[i] < LIM)     starve_d[i] = starve_q[i] + 1'b1;
            else                            starve_d[i] = starve_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) starve_q[i] <= '0;
        end else if (state_q == ST_SELECT) begin
            for (int i = 0; i < 4; i++) starve_q[i] <= starve_d[i];
        end
    end
`else
    assign sel_grant = arb_grant;
`endif

    always_comb begin
        sel_id   = QID_Q1;
        sel_head = head1;
        unique case (1'b1)
            sel_grant[0]: begin sel_id = QID_Q1; sel_head = head1; end
            sel_grant[1]: begin sel_id = QID_Q2; sel_head = head2; end
            sel_grant[2]: begin sel_id = QID_Q3; sel_head = head3; end
            sel_grant[3]: begin sel_id = QID_Q4; sel_head = head4; end
            default:      begin sel_id = QID_Q1; sel_head = head1; end
        endcase
    end

    assign ct_d = ct_q + 1'b1;

    // Outputs are loaded on the SELECT->ISSUE edge so they are visible
    // during ISSUE, two cycles after the accepted tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            pop_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ct_q        <= '0;
        end else begin
            pop_q       <= '0;
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (read_tick || pending_q) begin
                        state_q   <= ST_SELECT;
                        pending_q <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    state_q <= ST_ISSUE;
                    if (read_tick) pending_q <= 1'b1;
                    if (arb_any) begin
                        pop_q       <= sel_grant;
                        out_data_q  <= {sel_id, sel_head};
                        out_valid_q <= 1'b1;
                        ct_q        <= ct_d;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_SETTLE;
                    if (read_tick) pending_q <= 1'b1;
                end
                ST_SETTLE: begin
                    // A pending or fresh tick restarts directly, giving a
                    // 3-cycle packet spacing.
                    pending_q <= 1'b0;
                    if (pending_q || read_tick) state_q <= ST_SELECT;
                    else                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pop         = pop_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign ct_received = ct_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qos_output_scheduler.sv
// Self-checking bench for qos_output_scheduler: directed scenarios plus
// randomized occupancy patterns against a table-driven reference model.
module tb_qos_output_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       read_tick = 1'b0;
    logic [2:0] occ  [4];
    logic [1:0] head [4];
    logic [3:0] pop;
    logic [3:0] out_data;
    logic       out_valid;
    logic [9:0] ct_received;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    int         m_occ [4];
    int         m_starve [4];
    int         m_ct;
    logic [3:0] m_data;

    int wt_tab [4][7] = '{'{0, 9, 13, 15, 16, 17, 19},
                          '{0, 6, 8, 12, 14, 18, 21},
                          '{0, 3, 5, 7, 11, 19, 23},
                          '{0, 1, 2, 4, 10, 22, 24}};

    always #5 clk = ~clk;

    qos_output_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .read_tick   (read_tick),
        .occ1        (occ[0]),
        .occ2        (occ[1]),
        .occ3        (occ[2]),
        .occ4        (occ[3]),
        .head1       (head[0]),
        .head2       (head[1]),
        .head3       (head[2]),
        .head4       (head[3]),
        .pop         (pop),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .ct_received (ct_received),
        .busy        (busy)
    );

    function automatic int sat(input int o);
        return (o > 6) ? 6 : o;
    endfunction

    // Returns winning queue index 0..3, or -1 when every queue is empty.
    function automatic int model_pick();
        int s [4];
        int w [4];
        int win;
        int best;
        win  = -1;
        best = -1;
        for (int i = 0; i < 4; i++) begin
            s[i] = sat(m_occ[i]);
            w[i] = wt_tab[i][s[i]];
        end
        if (s[2] == 5 && s[0] == 6) begin
            if (s[1] < 5) w[0] = 20;
            else          w[2] = 20;
        end
`ifdef QOS_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++)
            if (win < 0 && s[i] > 0 && m_starve[i] >= 8) win = i;
        if (win >= 0) return win;
`endif
        for (int i = 0; i < 4; i++) begin
            if (s[i] > 0 && w[i] > best) begin
                best = w[i];
                win  = i;
            end
        end
        return win;
    endfunction

    function automatic void model_commit(input int win);
        logic [1:0] wid;
        for (int i = 0; i < 4; i++) begin
            if (m_occ[i] == 0 || i == win) m_starve[i] = 0;
            else                          m_starve[i] = m_starve[i] + 1;
        end
        if (win >= 0) begin
            wid    = win[1:0];
            m_data = {wid, head[win]};
            m_ct   = (m_ct + 1) % 1024;
        end
    endfunction

    task automatic model_reset();
        m_ct   = 0;
        m_data = 4'b0;
        for (int i = 0; i < 4; i++) m_starve[i] = 0;
    endtask

    task automatic set_in(input logic [11:0] o, input logic [7:0] h);
        for (int i = 0; i < 4; i++) begin
            occ[i]   = o[3*i +: 3];
            m_occ[i] = int'(o[3*i +: 3]);
            head[i]  = h[2*i +: 2];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        read_tick = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Starts at a negedge in IDLE; samples outputs in the ISSUE cycle and
    // returns at a negedge with the FSM back in IDLE.
    task automatic run_tx(output logic [3:0] o_pop, output logic [3:0] o_data,
                          output logic o_valid, output logic [9:0] o_ct);
        read_tick = 1'b1;
        @(negedge clk);
        read_tick = 1'b0;
        @(negedge clk);
        o_pop   = pop;
        o_data  = out_data;
        o_valid = out_valid;
        o_ct    = ct_received;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        set_in(12'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({pop, out_data, out_valid, ct_received, busy} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_state: got pop=%b data=%b v=%b ct=%0d busy=%b want all 0",
                     pop, out_data, out_valid, ct_received, busy);
        end
        reset = 1'b1;
        set_in({3'd0, 3'd0, 3'd0, 3'd1}, 8'b00_00_00_11);
        @(negedge clk);
        read_tick = 1'b1;
        @(negedge clk);
        read_tick = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || pop !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_pre_issue: got v=%b pop=%b want v=1 pop=0001",
                     out_valid, pop);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({pop, out_data, out_valid, ct_received, busy} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_mid_issue: got pop=%b data=%b v=%b ct=%0d busy=%b want all 0",
                     pop, out_data, out_valid, ct_received, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || pop !== 4'b0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b pop=%b want 0 0", busy, pop);
        end
    endtask

    task automatic test_basic();
        logic [3:0] p, d;
        logic       v;
        logic [9:0] c;
        do_reset();
        set_in({3'd5, 3'd0, 3'd0, 3'd1}, 8'b10_00_00_00);
        run_tx(p, d, v, c);
        model_commit(model_pick());
        n_cmp++;
        if (p !== 4'b1000 || d !== 4'b1110 || v !== 1'b1 || c !== 10'd1) begin
            n_err++;
            $display("FAIL basic_q4: got pop=%b data=%b v=%b ct=%0d want 1000 1110 1 1",
                     p, d, v, c);
        end
        n_cmp++;
        if (d !== m_data || c !== m_ct[9:0]) begin
            n_err++;
            $display("FAIL basic_model: got data=%b ct=%0d want %b %0d", d, c, m_data, m_ct);
        end
    endtask

    task automatic test_override();
        logic [3:0] p, d;
        logic       v;
        logic [9:0] c;
        do_reset();
        set_in({3'd0, 3'd5, 3'd4, 3'd6}, 8'b11_10_01_00);
        run_tx(p, d, v, c);
        model_commit(model_pick());
        n_cmp++;
        if (p !== 4'b0001 || d !== 4'b0000 || v !== 1'b1) begin
            n_err++;
            $display("FAIL override_q1: got pop=%b data=%b v=%b want 0001 0000 1", p, d, v);
        end
        set_in({3'd0, 3'd5, 3'd5, 3'd6}, 8'b11_10_01_00);
        run_tx(p, d, v, c);
        model_commit(model_pick());
        n_cmp++;
        if (p !== 4'b0100 || d !== 4'b1010 || c !== m_ct[9:0]) begin
            n_err++;
            $display("FAIL override_q3: got pop=%b data=%b ct=%0d want 0100 1010 %0d",
                     p, d, c, m_ct);
        end
    endtask

    task automatic test_empty();
        logic [3:0] p, d;
        logic       v;
        logic [9:0] c;
        do_reset();
        set_in({3'd0, 3'd2, 3'd0, 3'd0}, 8'b00_11_00_00);
        run_tx(p, d, v, c);
        model_commit(model_pick());
        set_in(12'd0, 8'hFF);
        run_tx(p, d, v, c);
        model_commit(model_pick());
        n_cmp++;
        if (p !== 4'b0 || v !== 1'b0) begin
            n_err++;
            $display("FAIL empty_nopop: got pop=%b v=%b want 0000 0", p, v);
        end
        n_cmp++;
        if (d !== 4'b1011 || c !== 10'd1 || d !== m_data) begin
            n_err++;
            $display("FAIL empty_hold: got data=%b ct=%0d want 1011 1", d, c);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_p;
        int         w;
        bit         extra;
        do_reset();
        set_in({3'd3, 3'd1, 3'd6, 3'd2}, 8'b01_10_11_00);
        extra     = 1'b0;
        read_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        w = model_pick();
        exp_p = 4'b0001 << w;
        model_commit(w);
        n_cmp++;
        if (out_valid !== 1'b1 || pop !== exp_p || out_data !== m_data) begin
            n_err++;
            $display("FAIL b2b_first: got v=%b pop=%b data=%b want 1 %b %b",
                     out_valid, pop, out_data, exp_p, m_data);
        end
        @(negedge clk);
        read_tick = 1'b0;
        if (out_valid !== 1'b0) extra = 1'b1;
        @(negedge clk);
        if (out_valid !== 1'b0) extra = 1'b1;
        @(negedge clk);
        w = model_pick();
        exp_p = 4'b0001 << w;
        model_commit(w);
        n_cmp++;
        if (out_valid !== 1'b1 || pop !== exp_p || ct_received !== m_ct[9:0]) begin
            n_err++;
            $display("FAIL b2b_second: got v=%b pop=%b ct=%0d want 1 %b %0d",
                     out_valid, pop, ct_received, exp_p, m_ct);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) extra = 1'b1;
        end
        n_cmp++;
        if (extra || busy !== 1'b0 || ct_received !== 10'd2) begin
            n_err++;
            $display("FAIL b2b_third_ignored: got extra=%b busy=%b ct=%0d want 0 0 2",
                     extra, busy, ct_received);
        end
    endtask

    task automatic test_starve();
        logic [3:0] p, d, exp_p;
        logic       v;
        logic [9:0] c;
        int         bad;
        do_reset();
        set_in({3'd6, 3'd0, 3'd0, 3'd1}, 8'b01_00_00_10);
        bad = 0;
        for (int k = 1; k <= 9; k++) begin
            run_tx(p, d, v, c);
            model_commit(model_pick());
            exp_p = 4'b1000;
`ifdef QOS_STARVE_GUARD_EN
            if (k == 9) exp_p = 4'b0001;
`endif
            n_cmp++;
            if (p !== exp_p || d !== m_data) begin
                n_err++;
                $display("FAIL starve_tick%0d: got pop=%b data=%b want %b %b",
                         k, p, d, exp_p, m_data);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  p, d, exp_p;
        logic        v;
        logic [9:0]  c;
        logic [11:0] o;
        int          w;
        int          errs;
        do_reset();
        errs = 0;
        for (int k = 0; k < 1040; k++) begin
            o = 12'($urandom);
            if ($urandom_range(0, 7) == 0) o = 12'd0;
            set_in(o, 8'($urandom));
            run_tx(p, d, v, c);
            w = model_pick();
            exp_p = (w < 0) ? 4'b0 : (4'b0001 << w);
            model_commit(w);
            n_cmp++;
            if (p !== exp_p || v !== (w >= 0) || d !== m_data || c !== m_ct[9:0]) begin
                n_err++;
                errs++;
                if (errs < 10)
                    $display("FAIL random_%0d occ=%h: got pop=%b v=%b data=%b ct=%0d want %b %b %b %0d",
                             k, o, p, v, d, c, exp_p, w >= 0, m_data, m_ct);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_override();
        test_empty();
        test_back_to_back();
        test_starve();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
